// File: rtl/ksa_pkg.sv
// Shared types and constants for the byte-serial Kogge-Stone add/subtract sequencer.
package ksa_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

endpackage

// File: rtl/ksa8_cin.sv
// 8-bit Kogge-Stone adder slice with carry-in; also exposes the carry into the top bit
// so the sequencer can derive signed overflow.
module ksa8_cin
   import ksa_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              cin,
   output logic [BYTE_W-1:0] sum,
   output logic              cout,
   output logic              c_msb
);

   logic [BYTE_W-1:0] p_bit;
   logic [BYTE_W-1:0] g;
   logic [BYTE_W-1:0] p;
   logic [BYTE_W-1:0] g_nxt;
   logic [BYTE_W-1:0] p_nxt;

   // Square cells, then log2(8) prefix levels. Once a group already reaches bit 0
   // (which includes cin), only its generate matters, so those nodes are triangles.
   always_comb begin
      p_bit = a ^ b;
      g     = a & b;
      p     = p_bit;
      g[0]  = g[0] | (p[0] & cin);
      g_nxt = g;
      p_nxt = p;
      for (int d = 1; d < BYTE_W; d = d * 2) begin
         g_nxt = g;
         p_nxt = p;
         for (int i = d; i < BYTE_W; i++) begin
            g_nxt[i] = g[i] | (p[i] & g[i-d]);
            if (i >= 2 * d) begin
               p_nxt[i] = p[i] & p[i-d];
            end
         end
         g = g_nxt;
         p = p_nxt;
      end
   end

   assign sum   = p_bit ^ {g[BYTE_W-2:0], cin};
   assign cout  = g[BYTE_W-1];
   assign c_msb = g[BYTE_W-2];

endmodule

// File: rtl/ksa_serial_add32.sv
// Byte-serial wide add/subtract: one shared 8-bit Kogge-Stone slice processes the operands
// LSB byte first, chaining the carry through a register, and returns sum plus flags.
module ksa_serial_add32
   import ksa_pkg::*;
#(
   parameter int BYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*BYTES-1:0]    in_a,
   input  logic [8*BYTES-1:0]    in_b,
   input  logic                  in_sub,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*BYTES-1:0]    out_sum,
   output logic                  out_cout,
   output logic                  out_ovf,
   output logic                  out_zero
);

   localparam int N     = BYTE_W * BYTES;
   localparam int IDX_W = $clog2(BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

   state_t            state;
   state_t            state_next;
   logic [N-1:0]      a_reg;
   logic [N-1:0]      b_reg;
   logic              carry;
   logic [IDX_W-1:0]  idx;
   logic              accept;
   logic              last_byte;
   logic [N-1:0]      sum_next;
   logic [BYTE_W-1:0] slice_sum;
   logic              slice_cout;
   logic              slice_msb;

   ksa8_cin u_slice (
      .a     (a_reg[BYTE_W*idx +: BYTE_W]),
      .b     (b_reg[BYTE_W*idx +: BYTE_W]),
      .cin   (carry),
      .sum   (slice_sum),
      .cout  (slice_cout),
      .c_msb (slice_msb)
   );

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (idx == LAST_IDX) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               in_ready   = 1'b1;
               state_next = in_valid ? RUN : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign accept    = in_valid & in_ready;
   assign last_byte = (state == RUN) && (idx == LAST_IDX);
   assign out_valid = (state == DONE);

   // The zero flag must see the final byte, which is only landing in out_sum this cycle.
   always_comb begin
      sum_next = out_sum;
      sum_next[BYTE_W*idx +: BYTE_W] = slice_sum;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg    <= '0;
         b_reg    <= '0;
         carry    <= 1'b0;
         idx      <= '0;
         out_sum  <= '0;
         out_cout <= 1'b0;
         out_ovf  <= 1'b0;
         out_zero <= 1'b0;
      end else if (accept) begin
         a_reg <= in_a;
         b_reg <= in_sub ? ~in_b : in_b;
         carry <= in_sub;
         idx   <= '0;
      end else if (state == RUN) begin
         out_sum <= sum_next;
         carry   <= slice_cout;
         if (last_byte) begin
            out_cout <= slice_cout;
            out_ovf  <= slice_msb ^ slice_cout;
            out_zero <= (sum_next == '0);
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ksa_serial_add32.sv
// Scoreboard bench for ksa_serial_add32: the driver queues hand-computed results at
// acceptance, and an independent monitor checks each result as it is handed off.
module tb_ksa_serial_add32;

   localparam int BYTES = 4;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        in_sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_sum;
   logic        out_cout;
   logic        out_ovf;
   logic        out_zero;

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   fails  = 0;
   int   cycle  = 0;
   bit   prev_valid = 1'b0;
   int   waited;

   ksa_serial_add32 #(.BYTES(BYTES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .out_zero  (out_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle++;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                input logic rdy, input logic [31:0] esum, input logic ec,
                                input logic eo, input logic ez, output int tries);
      exp_t e;
      bit   accepted;
      accepted = 1'b0;
      tries    = 0;
      @(negedge clk);
      in_a      = a;
      in_b      = b;
      in_sub    = sub;
      in_valid  = 1'b1;
      out_ready = rdy;
      while (!accepted && tries < 50) begin
         #1;
         if (in_ready) begin
            @(posedge clk);
            #1;
            e.sum  = esum;
            e.cout = ec;
            e.ovf  = eo;
            e.zero = ez;
            e.acc  = cycle;
            sb.push_back(e);
            accepted = 1'b1;
         end else begin
            @(negedge clk);
            tries++;
         end
      end
      in_valid = 1'b0;
      if (!accepted) begin
         checks++;
         fails++;
         $display("[TB] FAIL accept_timeout: got no acceptance, expected in_ready within 50 cycles");
      end
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      #3;
      if (sb.size() > 0) begin
         checks++;
         fails++;
         $display("[TB] FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
      end
   endtask

   // Monitor: latency on each rising out_valid, result contents on each handshake.
   always @(negedge clk) begin
      #2;
      if (!rst_n) begin
         prev_valid = 1'b0;
      end else begin
         if (out_valid && !prev_valid) begin
            if (sb.size() == 0) begin
               checks++;
               fails++;
               $display("[TB] FAIL unexpected_result: got out_valid with sum 0x%0h, expected none", out_sum);
            end else begin
               checkOutput("latency", 64'(cycle - sb[0].acc), 64'(BYTES));
            end
         end
         if (out_valid && out_ready && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("sum", 64'(out_sum), 64'(e.sum));
            checkOutput("cout", 64'(out_cout), 64'(e.cout));
            checkOutput("ovf", 64'(out_ovf), 64'(e.ovf));
            checkOutput("zero", 64'(out_zero), 64'(e.zero));
         end
         prev_valid = out_valid;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_sub    = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
      checkOutput("rst_out_sum", 64'(out_sum), 64'd0);
      checkOutput("rst_flags", 64'({out_cout, out_ovf, out_zero}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, waited);
      applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, waited);
      applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, waited);
      applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, waited);
      applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, waited);
      applyStimulus(32'h0000_0007, 32'h0000_0007, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, waited);
      waitDrain();

      // Backpressure: hold a finished result for 10 cycles, then release with a new op waiting.
      applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, waited);
      n = 0;
      do begin
         @(negedge clk);
         #2;
         n++;
      end while (!out_valid && n < 20);
      repeat (10) begin
         @(negedge clk);
         #2;
         checkOutput("hold_valid", 64'(out_valid), 64'd1);
         checkOutput("hold_sum", 64'(out_sum), 64'h2345_6789);
         checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
      end
      applyStimulus(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 1'b1, 32'h4B4B_4B4B, 1'b1, 1'b1, 1'b0, waited);
      checkOutput("b2b_same_edge_accept", 64'(waited), 64'd0);
      waitDrain();

      // Reset in the middle of a run, two bytes in.
      applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, waited);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      sb.delete();
      checkOutput("midrun_rst_valid", 64'(out_valid), 64'd0);
      checkOutput("midrun_rst_sum", 64'(out_sum), 64'd0);
      checkOutput("midrun_rst_flags", 64'({out_cout, out_ovf, out_zero}), 64'd0);
      checkOutput("midrun_rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b1, waited);
      applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_6789, 1'b0, 1'b0, 1'b0, waited);
      waitDrain();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
